pipe_hazard_ctrl: RTL and testbench

Central stall/flush/freeze sequencer for the 5-stage pipeline. It detects RAW hazards between the ID stage and the EX/MEM destinations and inserts bubbles into the ID/EX register. It flushes wrong-path instructions on a taken branch. It freezes the whole pipeline for a fixed number of cycles while the MEM stage waits on the multi-cycle data memory. It drives the PC, IF/ID, ID/EX and downstream register control inputs.

---
 rtl/pipe_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush/freeze sequencer: RAW hazard bubbles, branch flush, data-memory freeze.
// Optional stall performance counter enabled by defining STALL_CNT_EN.
`ifndef REG_FILE_DEPTH
`define REG_FILE_DEPTH 4
`endif

module pipe_hazard_ctrl #(
  parameter int MEM_WAIT_CYCLES = 4,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [`REG_FILE_DEPTH-1:0] id_src1,
  input  logic [`REG_FILE_DEPTH-1:0] id_src2,
  input  logic                       id_two_src,
  input  logic                       id_valid,
  input  logic [`REG_FILE_DEPTH-1:0] ex_dst,
  input  logic [`REG_FILE_DEPTH-1:0] mem_dst,
  input  logic                       ex_wb_en,
  input  logic                       mem_wb_en,
  input  logic                       ex_branch,
  input  logic                       mem_req,
  input  logic                       stall_cnt_clr,
  output logic                       pc_stall,
  output logic                       if_flush,
  output logic                       id_flush,
  output logic                       freeze,
  output logic                       mem_ready,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  localparam int CNT_W = $clog2(MEM_WAIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (MEM_WAIT_CYCLES >= 2) ? CNT_W'(MEM_WAIT_CYCLES - 2) : {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             hazard_s;
  logic             freeze_s, mem_ready_s;
  logic             pc_stall_s, if_flush_s, id_flush_s;

  // RAW hazard detection against EX and MEM destinations (no forwarding)
  always_comb begin
    hazard_s = (id_valid &
                ((ex_wb_en & (id_src1 == ex_dst)) | (mem_wb_en & (id_src1 == mem_dst)))) |
               (id_two_src &
                ((ex_wb_en & (id_src2 == ex_dst)) | (mem_wb_en & (id_src2 == mem_dst))));
  end

  // Memory-wait FSM next-state and freeze/ready decode
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    freeze_s    = 1'b0;
    mem_ready_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (mem_req) begin
          freeze_s = 1'b1;
          if (MEM_WAIT_CYCLES == 1) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = CNT_LOAD;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_WAIT: begin
        freeze_s = 1'b1;
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s = ST_DONE;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1'b1);
        end
      end
      // mem_req here still belongs to the access just completed
      ST_DONE: begin
        mem_ready_s = 1'b1;
        state_nxt_s = ST_RUN;
      end
      default: begin
        state_nxt_s = ST_RUN;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Stall/flush priority: freeze > branch > hazard
  always_comb begin
    pc_stall_s = 1'b0;
    if_flush_s = 1'b0;
    id_flush_s = 1'b0;
    if (freeze_s) begin
      pc_stall_s = 1'b0;
    end else if (ex_branch) begin
      if_flush_s = 1'b1;
      id_flush_s = 1'b1;
    end else if (hazard_s) begin
      pc_stall_s = 1'b1;
      id_flush_s = 1'b1;
    end else begin
      pc_stall_s = 1'b0;
    end
  end

  // FSM state and wait counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

`ifdef STALL_CNT_EN
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_r;

  // Saturating count of cycles lost to freeze or stall; clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {STALL_CNT_WIDTH{1'b0}};
    end else if (stall_cnt_clr) begin
      stall_cnt_r <= {STALL_CNT_WIDTH{1'b0}};
    end else if ((freeze_s | pc_stall_s) && !(&stall_cnt_r)) begin
      stall_cnt_r <= stall_cnt_r + STALL_CNT_WIDTH'(1'b1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_count = stall_cnt_r;
`else
  logic unused_clr_s;
  assign unused_clr_s = stall_cnt_clr;
  assign stall_count  = {STALL_CNT_WIDTH{1'b0}};
`endif

  assign pc_stall  = pc_stall_s;
  assign if_flush  = if_flush_s;
  assign id_flush  = id_flush_s;
  assign freeze    = freeze_s;
  assign mem_ready = mem_ready_s;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MEM_WAIT_CYCLES=4 and =1 instances).
`ifndef REG_FILE_DEPTH
`define REG_FILE_DEPTH 4
`endif

module tb_pipe_hazard_ctrl;

  logic                       clk;
  logic                       rst;
  logic [`REG_FILE_DEPTH-1:0] id_src1, id_src2, ex_dst, mem_dst;
  logic                       id_two_src, id_valid, ex_wb_en, mem_wb_en;
  logic                       ex_branch, mem_req, stall_cnt_clr;

  logic        pc_stall_a, if_flush_a, id_flush_a, freeze_a, mem_ready_a;
  logic [15:0] cnt_a;
  logic        pc_stall_b, if_flush_b, id_flush_b, freeze_b, mem_ready_b;
  logic [3:0]  cnt_b;
  logic [4:0]  outs_a, outs_b;

  int total;
  int bad;

  // {freeze, mem_ready, pc_stall, if_flush, id_flush}
  assign outs_a = {freeze_a, mem_ready_a, pc_stall_a, if_flush_a, id_flush_a};
  assign outs_b = {freeze_b, mem_ready_b, pc_stall_b, if_flush_b, id_flush_b};

  pipe_hazard_ctrl #(.MEM_WAIT_CYCLES(4), .STALL_CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_valid(id_valid), .ex_dst(ex_dst), .mem_dst(mem_dst),
    .ex_wb_en(ex_wb_en), .mem_wb_en(mem_wb_en), .ex_branch(ex_branch), .mem_req(mem_req),
    .stall_cnt_clr(stall_cnt_clr), .pc_stall(pc_stall_a), .if_flush(if_flush_a),
    .id_flush(id_flush_a), .freeze(freeze_a), .mem_ready(mem_ready_a), .stall_count(cnt_a)
  );

  pipe_hazard_ctrl #(.MEM_WAIT_CYCLES(1), .STALL_CNT_WIDTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_valid(id_valid), .ex_dst(ex_dst), .mem_dst(mem_dst),
    .ex_wb_en(ex_wb_en), .mem_wb_en(mem_wb_en), .ex_branch(ex_branch), .mem_req(mem_req),
    .stall_cnt_clr(stall_cnt_clr), .pc_stall(pc_stall_b), .if_flush(if_flush_b),
    .id_flush(id_flush_b), .freeze(freeze_b), .mem_ready(mem_ready_b), .stall_count(cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_src1 = 4'd0; id_src2 = 4'd0; ex_dst = 4'd0; mem_dst = 4'd0;
    id_two_src = 1'b0; id_valid = 1'b0; ex_wb_en = 1'b0; mem_wb_en = 1'b0;
    ex_branch = 1'b0; mem_req = 1'b0; stall_cnt_clr = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_cnt3, exp_cnt20, exp_cnt20_b, exp_fz_a, exp_fz_b, exp_one;
`ifdef STALL_CNT_EN
    exp_cnt3 = 32'd3; exp_cnt20 = 32'd20; exp_cnt20_b = 32'd15;
    exp_fz_a = 32'd4; exp_fz_b = 32'd1; exp_one = 32'd1;
`else
    exp_cnt3 = 32'd0; exp_cnt20 = 32'd0; exp_cnt20_b = 32'd0;
    exp_fz_a = 32'd0; exp_fz_b = 32'd0; exp_one = 32'd0;
`endif
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle();
    #2;
    chk("reset_outs", 32'(outs_a), 32'b00000);
    chk("reset_cnt", 32'(cnt_a), 32'd0);
    rst = 1'b0;
    tick();

    // RAW hazard against EX, then MEM, then clear
    id_valid = 1'b1; id_src1 = 4'd3; ex_wb_en = 1'b1; ex_dst = 4'd3;
    #1 chk("raw_ex", 32'(outs_a), 32'b00101);
    tick();
    ex_wb_en = 1'b0; ex_dst = 4'd0; mem_wb_en = 1'b1; mem_dst = 4'd3;
    #1 chk("raw_mem", 32'(outs_a), 32'b00101);
    tick();
    mem_wb_en = 1'b0;
    #1 chk("raw_gone", 32'(outs_a), 32'b00000);

    // second source only counts when id_two_src is set
    id_valid = 1'b0; id_src2 = 4'd5; ex_dst = 4'd5; ex_wb_en = 1'b1;
    #1 chk("src2_unused", 32'(outs_a), 32'b00000);
    id_two_src = 1'b1;
    #1 chk("src2_ex", 32'(outs_a), 32'b00101);
    ex_wb_en = 1'b0; mem_dst = 4'd5; mem_wb_en = 1'b1;
    #1 chk("src2_mem", 32'(outs_a), 32'b00101);
    mem_wb_en = 1'b0;
    #1 chk("src2_no_wb", 32'(outs_a), 32'b00000);

    // branch overrides a simultaneous hazard
    mem_wb_en = 1'b1; ex_branch = 1'b1;
    #1 chk("branch_hazard", 32'(outs_a), 32'b00011);
    idle();
    tick();

    // held mem_req: A freezes 4 cycles then DONE; B (1 cycle) alternates
    mem_req = 1'b1;
    #1;
    for (int c = 0; c < 9; c++) begin
      chk($sformatf("frz4_c%0d", c), 32'(outs_a), (c == 4) ? 32'b01000 : 32'b10000);
      chk($sformatf("frz1_c%0d", c), 32'(outs_b), (c % 2 == 0) ? 32'b10000 : 32'b01000);
      tick();
    end
    // cycle 9: both in DONE, branch logic active
    ex_branch = 1'b1;
    #1 chk("done_branch_a", 32'(outs_a), 32'b01011);
    chk("done_branch_b", 32'(outs_b), 32'b01011);
    idle();
    tick();
    chk("after_done", 32'(outs_a), 32'b00000);

    // async reset mid-WAIT while a branch is pending
    mem_req = 1'b1; ex_branch = 1'b1;
    #1 chk("frz_branch_c0", 32'(outs_a), 32'b10000);
    tick();
    mem_req = 1'b0;
    #1 chk("frz_branch_c1", 32'(outs_a), 32'b10000);
    tick();
    chk("frz_branch_c2", 32'(outs_a), 32'b10000);
    rst = 1'b1;
    #1 chk("rst_mid_wait", 32'(outs_a), 32'b00011);
    ex_branch = 1'b0;
    #1 chk("rst_idle", 32'(outs_a), 32'b00000);
    rst = 1'b0;
    tick();
    chk("rst_run", 32'(outs_a), 32'b00000);

    // counter: freeze cycles of one access
    stall_cnt_clr = 1'b1;
    tick();
    stall_cnt_clr = 1'b0;
    chk("cnt_clr_a", 32'(cnt_a), 32'd0);
    mem_req = 1'b1;
    tick();
    mem_req = 1'b0;
    repeat (4) tick();
    chk("cnt_frz_a", 32'(cnt_a), exp_fz_a);
    chk("cnt_frz_b", 32'(cnt_b), exp_fz_b);

    // counter: hazard stalls with saturation on the 4-bit instance
    stall_cnt_clr = 1'b1;
    tick();
    stall_cnt_clr = 1'b0;
    id_valid = 1'b1; id_src1 = 4'd3; ex_wb_en = 1'b1; ex_dst = 4'd3;
    repeat (3) tick();
    chk("cnt_3_a", 32'(cnt_a), exp_cnt3);
    chk("cnt_3_b", 32'(cnt_b), exp_cnt3);
    repeat (17) tick();
    chk("cnt_20_a", 32'(cnt_a), exp_cnt20);
    chk("cnt_sat_b", 32'(cnt_b), exp_cnt20_b);
    stall_cnt_clr = 1'b1;
    tick();
    chk("cnt_clr_prio_a", 32'(cnt_a), 32'd0);
    chk("cnt_clr_prio_b", 32'(cnt_b), 32'd0);
    stall_cnt_clr = 1'b0;
    tick();
    chk("cnt_resume_a", 32'(cnt_a), exp_one);

    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
